data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl_pkg.sv | 66 ++++++
 rtl/data_mem_ctrl_load_align.sv | 45 ++++
 rtl/data_mem_ctrl.sv | 166 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl_pkg
// Shared definitions for the data memory controller:
//   - FSM state encoding (IDLE / WAIT / DONE)
//   - funct3 access size/sign encodings
//   - helpers for request legality, store byte enables and store data lanes
// No ports; imported by data_mem_ctrl and data_mem_ctrl_load_align.
// ---------------------------------------------------------------------------
package data_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] F3_BYTE   = 3'b000;
  localparam logic [2:0] F3_HALF   = 3'b001;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_BYTE_U = 3'b100;
  localparam logic [2:0] F3_HALF_U = 3'b101;

  // A request is legal when its funct3 exists for that direction (stores
  // have no unsigned forms) and the address is naturally aligned.
  function automatic logic is_legal_access(input logic       i_isStore,
                                           input logic [2:0] i_funct3,
                                           input logic [1:0] i_offset);
    logic legal;
    legal = 1'b0;
    case (i_funct3)
      F3_BYTE:   legal = 1'b1;
      F3_HALF:   legal = ~i_offset[0];
      F3_WORD:   legal = (i_offset == 2'b00);
      F3_BYTE_U: legal = ~i_isStore;
      F3_HALF_U: legal = ~i_isStore & ~i_offset[0];
      default:   legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Byte lanes touched by a store of the given size at the given offset.
  function automatic logic [3:0] store_byte_enable(input logic [2:0] i_funct3,
                                                   input logic [1:0] i_offset);
    logic [3:0] be;
    case (i_funct3)
      F3_BYTE: be = 4'b0001 << i_offset;
      F3_HALF: be = 4'b0011 << {i_offset[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the low store bytes across the word so every enabled lane
  // sees the right data regardless of offset.
  function automatic logic [31:0] store_wdata(input logic [2:0]  i_funct3,
                                              input logic [31:0] i_wdata);
    logic [31:0] wd;
    case (i_funct3)
      F3_BYTE: wd = {4{i_wdata[7:0]}};
      F3_HALF: wd = {2{i_wdata[15:0]}};
      default: wd = i_wdata;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_load_align.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl_load_align
// Combinational load extraction: picks the addressed byte/half out of the
// bus word and sign- or zero-extends it according to funct3.
// Ports:
//   i_word    [31:0] word returned by memory
//   i_offset  [1:0]  byte offset of the access within the word
//   i_funct3  [2:0]  access size/sign
//   o_result  [31:0] aligned, extended load value
// ---------------------------------------------------------------------------
module data_mem_ctrl_load_align
  import data_mem_ctrl_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select first, then extension; word loads pass straight through.
  always_comb begin
    w_byte   = i_word[7:0];
    w_half   = i_offset[1] ? i_word[31:16] : i_word[15:0];
    o_result = i_word;

    case (i_offset)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase

    case (i_funct3)
      F3_BYTE:   o_result = {{24{w_byte[7]}}, w_byte};
      F3_HALF:   o_result = {{16{w_half[15]}}, w_half};
      F3_BYTE_U: o_result = {24'h000000, w_byte};
      F3_HALF_U: o_result = {16'h0000, w_half};
      default:   o_result = i_word;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
// Load/store unit between the core pipeline and a single-beat memory bus.
// A legal request is registered in IDLE, driven onto the bus in WAIT until
// bus_ack or timeout, and DONE releases the pipeline for exactly one cycle.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_read, mem_write   load / store request (store wins if both)
//   funct3 [2:0]          access size/sign
//   addr [31:0]           byte address
//   wdata [31:0]          store data (low bytes)
//   rdata [31:0]          last completed load result
//   stall                 hold the pipeline while an access is in flight
//   fault                 one-cycle pulse for a misaligned/illegal request
//   bus_err               one-cycle pulse when the bus timed out
//   bus_req/bus_we/bus_addr/bus_wdata/bus_be   bus request side
//   bus_ack/bus_rdata     bus completion side
// Parameter:
//   TIMEOUT               WAIT cycles without ack before giving up (<= 32)
// ---------------------------------------------------------------------------
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [4:0] LP_LAST_WAIT = 5'(TIMEOUT - 1);

  state_e      r_state;
  state_e      w_nextState;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic        r_we;
  logic [4:0]  r_waitCnt;
  logic [31:0] r_rdata;
  logic        r_fault;
  logic        r_busErr;

  logic        w_req;
  logic        w_legal;
  logic        w_accept;
  logic        w_illegal;
  logic        w_timeout;
  logic [31:0] w_loadResult;

  // Request qualification in IDLE. A store-shaped check is used whenever
  // mem_write is high so that a simultaneous read cannot sneak an unsigned
  // funct3 past the store legality rules.
  assign w_req     = mem_read | mem_write;
  assign w_legal   = is_legal_access(mem_write, funct3, addr[1:0]);
  assign w_accept  = (r_state == ST_IDLE) & w_req & w_legal;
  assign w_illegal = (r_state == ST_IDLE) & w_req & ~w_legal;

  // The counter value LP_LAST_WAIT marks the final WAIT cycle; an ack in
  // that same cycle still completes the access normally.
  assign w_timeout = (r_state == ST_WAIT) & ~bus_ack & (r_waitCnt == LP_LAST_WAIT);

  data_mem_ctrl_load_align load_align (
    .i_word   (bus_rdata),
    .i_offset (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .o_result (w_loadResult)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: DONE always falls back to IDLE after one cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_nextState = ST_WAIT;
      ST_WAIT: if (bus_ack || w_timeout) w_nextState = ST_DONE;
      ST_DONE: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Request capture, wait counter, load result and the two status pulses.
  // A store that times out leaves rdata alone, since stores never own it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      r_funct3  <= 3'b000;
      r_we      <= 1'b0;
      r_waitCnt <= 5'd0;
      r_rdata   <= 32'h0;
      r_fault   <= 1'b0;
      r_busErr  <= 1'b0;
    end else begin
      r_fault  <= w_illegal;
      r_busErr <= w_timeout;
      if (w_accept) begin
        r_addr    <= addr;
        r_wdata   <= wdata;
        r_funct3  <= funct3;
        r_we      <= mem_write;
        r_waitCnt <= 5'd0;
      end else if (r_state == ST_WAIT) begin
        if (bus_ack) begin
          if (!r_we) r_rdata <= w_loadResult;
        end else if (w_timeout) begin
          if (!r_we) r_rdata <= 32'h0;
        end else begin
          r_waitCnt <= r_waitCnt + 5'd1;
        end
      end
    end
  end

  // Pipeline and bus outputs. The bus is only driven during WAIT. The IDLE
  // stall term is gated by rst_n so a request held through reset cannot
  // stall the core while the controller is being cleared.
  always_comb begin
    stall     = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 32'h0;
    bus_wdata = 32'h0;
    bus_be    = 4'b0000;
    case (r_state)
      ST_IDLE: stall = w_accept & rst_n;
      ST_WAIT: begin
        stall     = 1'b1;
        bus_req   = 1'b1;
        bus_we    = r_we;
        bus_addr  = {r_addr[31:2], 2'b00};
        bus_be    = r_we ? store_byte_enable(r_funct3, r_addr[1:0]) : 4'b1111;
        bus_wdata = r_we ? store_wdata(r_funct3, r_wdata) : 32'h0;
      end
      default: ;
    endcase
  end

  assign rdata   = r_rdata;
  assign fault   = r_fault;
  assign bus_err = r_busErr;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl
// Directed self-checking bench for data_mem_ctrl. Inputs change on the
// falling clock edge; outputs are sampled 1ns later, away from the rising
// edge where the DUT updates.
// ---------------------------------------------------------------------------
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        fault;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int testsRun    = 0;
  int testsFailed = 0;

  // Results of the most recent doAccess call.
  int          accStall;
  int          accWait;
  logic [3:0]  accBe;
  logic [31:0] accWdata;
  logic [31:0] accAddr;
  logic        accWe;
  logic        accErrEarly;

  data_mem_ctrl #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .fault     (fault),
    .bus_err   (bus_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Presents one request for one cycle, acts as the memory (ack after
  // ackWait no-ack WAIT cycles, or never if ackWait < 0) and returns with
  // the FSM sitting in DONE. The WAIT loop is bounded at 64 cycles.
  task automatic doAccess(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] word, input int ackWait);
    accStall = 0; accWait = 0; accErrEarly = 1'b0;
    accBe = 4'h0; accWdata = 32'h0; accAddr = 32'h0; accWe = 1'b0;
    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    #1 if (stall) accStall++;
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    while (bus_req && accWait < 64) begin
      accBe = bus_be; accWdata = bus_wdata; accAddr = bus_addr; accWe = bus_we;
      if (bus_err) accErrEarly = 1'b1;
      if (accWait == ackWait) begin
        bus_ack = 1'b1; bus_rdata = word;
      end
      #1 if (stall) accStall++;
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = 32'h0;
      accWait++;
    end
    #1 if (stall) accStall++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
    addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    #2;
    testsRun++; if (stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset stall: got %b, expected 0", stall); end
    testsRun++; if (bus_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset bus_req: got %b, expected 0", bus_req); end
    testsRun++; if (bus_we !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset bus_we: got %b, expected 0", bus_we); end
    testsRun++; if (bus_be !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset bus_be: got %b, expected 0000", bus_be); end
    testsRun++; if (fault !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset fault: got %b, expected 0", fault); end
    testsRun++; if (bus_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset bus_err: got %b, expected 0", bus_err); end
    testsRun++; if (rdata !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset rdata: got %h, expected 00000000", rdata); end
    mem_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // Release reset and present a request straight away: the very next
    // rising edge must accept it.
    rst_n = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h40;
    #1;
    testsRun++; if (stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL first_req stall: got %b, expected 1", stall); end
    @(negedge clk);
    mem_read = 1'b0;
    testsRun++; if (bus_req !== 1'b1) begin testsFailed++; $display("[TB] FAIL first_req bus_req: got %b, expected 1", bus_req); end
    bus_ack = 1'b1; bus_rdata = 32'h11223344;
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = 32'h0;
    testsRun++; if (rdata !== 32'h11223344) begin testsFailed++; $display("[TB] FAIL first_req rdata: got %h, expected 11223344", rdata); end
  endtask

  task automatic test_lw_wait();
    doAccess(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1);
    testsRun++; if (accStall !== 3) begin testsFailed++; $display("[TB] FAIL lw_wait stall_cycles: got %0d, expected 3", accStall); end
    testsRun++; if (accWait !== 2) begin testsFailed++; $display("[TB] FAIL lw_wait wait_cycles: got %0d, expected 2", accWait); end
    testsRun++; if (rdata !== 32'hDEADBEEF) begin testsFailed++; $display("[TB] FAIL lw_wait rdata: got %h, expected deadbeef", rdata); end
    testsRun++; if (accBe !== 4'b1111) begin testsFailed++; $display("[TB] FAIL lw_wait bus_be: got %b, expected 1111", accBe); end
    testsRun++; if (accAddr !== 32'h100) begin testsFailed++; $display("[TB] FAIL lw_wait bus_addr: got %h, expected 00000100", accAddr); end
    testsRun++; if (accWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL lw_wait bus_we: got %b, expected 0", accWe); end
    testsRun++; if (bus_req !== 1'b0 || stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL lw_wait done_outputs: got req=%b stall=%b, expected 0/0", bus_req, stall); end
  endtask

  // Minimum-latency loads covering every lane and extension type.
  task automatic test_load_extend();
    logic [2:0]  f3Tab   [7] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b001, 3'b010};
    logic [31:0] addrTab [7] = '{32'h103, 32'h103, 32'h101, 32'h100, 32'h102, 32'h102, 32'h104};
    logic [31:0] wordTab [7] = '{32'h80000000, 32'h80000000, 32'h00007F00, 32'h1234F00D,
                                 32'hBEEF1234, 32'h7ABC0000, 32'hCAFEF00D};
    logic [31:0] expTab  [7] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F, 32'hFFFFF00D,
                                 32'h0000BEEF, 32'h00007ABC, 32'hCAFEF00D};
    for (int i = 0; i < 7; i++) begin
      doAccess(1'b1, 1'b0, f3Tab[i], addrTab[i], 32'h0, wordTab[i], 0);
      testsRun++; if (rdata !== expTab[i]) begin testsFailed++; $display("[TB] FAIL extend[%0d] rdata: got %h, expected %h", i, rdata, expTab[i]); end
      testsRun++; if (accStall !== 2) begin testsFailed++; $display("[TB] FAIL extend[%0d] stall_cycles: got %0d, expected 2", i, accStall); end
      testsRun++; if (accWait !== 1) begin testsFailed++; $display("[TB] FAIL extend[%0d] wait_cycles: got %0d, expected 1", i, accWait); end
    end
  endtask

  // Stores, including read+write together (write must win). rdata keeps
  // the last load value, 0xCAFEF00D.
  task automatic test_store();
    logic        rdTab  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3Tab  [5] = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b001};
    logic [31:0] aTab   [5] = '{32'h202, 32'h201, 32'h207, 32'h20C, 32'h200};
    logic [31:0] wdTab  [5] = '{32'h1234ABCD, 32'h000000A5, 32'hFFFFFF3C, 32'h01020304, 32'h0000BEEF};
    logic [31:0] eaTab  [5] = '{32'h200, 32'h200, 32'h204, 32'h20C, 32'h200};
    logic [3:0]  ebTab  [5] = '{4'b1100, 4'b0010, 4'b1000, 4'b1111, 4'b0011};
    logic [31:0] ewdTab [5] = '{32'hABCDABCD, 32'hA5A5A5A5, 32'h3C3C3C3C, 32'h01020304, 32'hBEEFBEEF};
    for (int i = 0; i < 5; i++) begin
      doAccess(rdTab[i], 1'b1, f3Tab[i], aTab[i], wdTab[i], 32'h55555555, i % 2);
      testsRun++; if (accAddr !== eaTab[i]) begin testsFailed++; $display("[TB] FAIL store[%0d] bus_addr: got %h, expected %h", i, accAddr, eaTab[i]); end
      testsRun++; if (accBe !== ebTab[i]) begin testsFailed++; $display("[TB] FAIL store[%0d] bus_be: got %b, expected %b", i, accBe, ebTab[i]); end
      testsRun++; if (accWdata !== ewdTab[i]) begin testsFailed++; $display("[TB] FAIL store[%0d] bus_wdata: got %h, expected %h", i, accWdata, ewdTab[i]); end
      testsRun++; if (accWe !== 1'b1) begin testsFailed++; $display("[TB] FAIL store[%0d] bus_we: got %b, expected 1", i, accWe); end
      testsRun++; if (rdata !== 32'hCAFEF00D) begin testsFailed++; $display("[TB] FAIL store[%0d] rdata: got %h, expected cafef00d", i, rdata); end
    end
  endtask

  // Illegal requests: fault one cycle later for one cycle, no stall, no bus.
  task automatic test_fault();
    logic        rdTab [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3Tab [6] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110};
    logic [31:0] aTab  [6] = '{32'h101, 32'h203, 32'h102, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mem_read = rdTab[i]; mem_write = ~rdTab[i]; funct3 = f3Tab[i]; addr = aTab[i]; wdata = 32'hFFFFFFFF;
      #1;
      testsRun++; if (stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL fault[%0d] stall: got %b, expected 0", i, stall); end
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      testsRun++; if (fault !== 1'b1) begin testsFailed++; $display("[TB] FAIL fault[%0d] pulse: got %b, expected 1", i, fault); end
      testsRun++; if (bus_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL fault[%0d] bus_req: got %b, expected 0", i, bus_req); end
      @(negedge clk);
      testsRun++; if (fault !== 1'b0) begin testsFailed++; $display("[TB] FAIL fault[%0d] pulse_end: got %b, expected 0", i, fault); end
      testsRun++; if (bus_req !== 1'b0 || stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL fault[%0d] idle: got req=%b stall=%b, expected 0/0", i, bus_req, stall); end
    end
  endtask

  task automatic test_timeout();
    doAccess(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, -1);
    testsRun++; if (accWait !== 16) begin testsFailed++; $display("[TB] FAIL timeout wait_cycles: got %0d, expected 16", accWait); end
    testsRun++; if (accErrEarly !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout early_err: got %b, expected 0", accErrEarly); end
    testsRun++; if (bus_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL timeout bus_err: got %b, expected 1", bus_err); end
    testsRun++; if (rdata !== 32'h0) begin testsFailed++; $display("[TB] FAIL timeout rdata: got %h, expected 00000000", rdata); end
    testsRun++; if (accStall !== 17) begin testsFailed++; $display("[TB] FAIL timeout stall_cycles: got %0d, expected 17", accStall); end
    @(negedge clk);
    testsRun++; if (bus_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout bus_err_end: got %b, expected 0", bus_err); end
  endtask

  task automatic test_ack_at_timeout();
    doAccess(1'b1, 1'b0, 3'b010, 32'h310, 32'h0, 32'h5A5A0001, 15);
    testsRun++; if (accWait !== 16) begin testsFailed++; $display("[TB] FAIL ack_timeout wait_cycles: got %0d, expected 16", accWait); end
    testsRun++; if (bus_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL ack_timeout bus_err: got %b, expected 0", bus_err); end
    testsRun++; if (rdata !== 32'h5A5A0001) begin testsFailed++; $display("[TB] FAIL ack_timeout rdata: got %h, expected 5a5a0001", rdata); end
  endtask

  task automatic test_ack_ignored();
    @(negedge clk);
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hFFFF0000;
    #1;
    testsRun++; if (bus_req !== 1'b0 || stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL ack_ignored idle: got req=%b stall=%b, expected 0/0", bus_req, stall); end
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = 32'h0;
    testsRun++; if (rdata !== 32'h5A5A0001) begin testsFailed++; $display("[TB] FAIL ack_ignored rdata: got %h, expected 5a5a0001", rdata); end
    testsRun++; if (bus_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL ack_ignored bus_req: got %b, expected 0", bus_req); end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400;
    @(negedge clk);
    mem_read = 1'b0;
    testsRun++; if (bus_req !== 1'b1) begin testsFailed++; $display("[TB] FAIL mid_wait bus_req_before: got %b, expected 1", bus_req); end
    #2 rst_n = 1'b0;
    #1;
    testsRun++; if (bus_req !== 1'b0 || stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_wait async_drop: got req=%b stall=%b, expected 0/0", bus_req, stall); end
    testsRun++; if (rdata !== 32'h0 || bus_be !== 4'b0000) begin testsFailed++; $display("[TB] FAIL mid_wait cleared: got rdata=%h be=%b, expected 0/0000", rdata, bus_be); end
    @(negedge clk);
    rst_n = 1'b1;
    doAccess(1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 32'h0BADF00D, 0);
    testsRun++; if (rdata !== 32'h0BADF00D) begin testsFailed++; $display("[TB] FAIL mid_wait next_rdata: got %h, expected 0badf00d", rdata); end
    testsRun++; if (accStall !== 2) begin testsFailed++; $display("[TB] FAIL mid_wait next_stall: got %0d, expected 2", accStall); end
  endtask

  initial begin
    test_reset();
    test_lw_wait();
    test_load_extend();
    test_store();
    test_fault();
    test_timeout();
    test_ack_at_timeout();
    test_ack_ignored();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
